// File: rtl/tm1638_key_reader_pkg.sv
// Shared TM1638 definitions: command bytes, key-reader state encoding,
// key bit positions and the LED&KEY key decode helper.
package tm1638_key_reader_pkg;

  localparam logic [7:0] TM1638_CMD_WRITE_AUTO  = 8'h40;
  localparam logic [7:0] TM1638_CMD_READ_KEYS   = 8'h42;
  localparam logic [7:0] TM1638_CMD_WRITE_FIXED = 8'h44;

  // Each received byte carries one key in bit 0 and one in bit 4.
  localparam int KEY_POS_LO = 0;
  localparam int KEY_POS_HI = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_CMD_LO = 3'd2,
    ST_CMD_HI = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RD_LO  = 3'd5,
    ST_RD_HI  = 3'd6,
    ST_STOP   = 3'd7
  } state_t;

  function automatic logic [7:0] decode_keys(
    input logic [31:0] raw
  );
    logic [7:0] k;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      k[i]   = raw[8*i + KEY_POS_LO];
      k[i+4] = raw[8*i + KEY_POS_HI];
    end
    return k;
  endfunction

endpackage

// File: rtl/tm1638_tick.sv
// TM1638 half-period prescaler: counts 0..DIV-1 while enabled.
// Ports: i_clk, i_rst (sync high), i_en, i_clr, o_tick (last count).
module tm1638_tick #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 16'd1;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends 0x42, clocks in 4 key bytes, decodes 8 keys.
// Ports: CLK_IN/RST_IN, READ/BUSY, KEYS/RAW/KEYS_VALID, STB/CLK/DIO pins.
module tm1638_key_reader
  import tm1638_key_reader_pkg::*;
#(
  parameter int CLOCK_DIV = 4,
  parameter int WAIT_HALF = 2
) (
  input  logic        CLK_IN,
  input  logic        RST_IN,
  input  logic        READ,
  output logic        BUSY,
  output logic [7:0]  KEYS,
  output logic [31:0] RAW,
  output logic        KEYS_VALID,
  output logic        TM1638_STB,
  output logic        TM1638_CLK,
  output logic        DIO_OUT,
  output logic        DIO_OE,
  input  logic        DIO_IN
);

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_HALF - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_idx;
  logic [31:0] r_shift;
  logic [31:0] r_raw;
  logic [7:0]  r_keys;
  logic        r_valid;

  logic w_tick;
  logic w_busy;
  logic w_accept;
  logic w_stb;
  logic w_clk;
  logic w_oe;
  logic w_do;

  assign w_busy = (r_state != ST_IDLE);

  tm1638_tick #(
    .DIV(CLOCK_DIV)
  ) u_tick (
    .i_clk (CLK_IN),
    .i_rst (RST_IN),
    .i_en  (w_busy),
    .i_clr (w_accept),
    .o_tick(w_tick)
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_stb    = 1'b0;
    w_clk    = 1'b1;
    w_oe     = 1'b0;
    w_do     = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_stb = 1'b1;
        if (READ) begin
          w_accept = 1'b1;
          w_next   = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) w_next = ST_CMD_LO;
      end
      ST_CMD_LO: begin
        w_clk = 1'b0;
        w_oe  = 1'b1;
        w_do  = TM1638_CMD_READ_KEYS[r_idx[2:0]];
        if (w_tick) w_next = ST_CMD_HI;
      end
      ST_CMD_HI: begin
        // Data held through the rising edge the chip latches on.
        w_oe = 1'b1;
        w_do = TM1638_CMD_READ_KEYS[r_idx[2:0]];
        if (w_tick) begin
          w_next = (r_idx == 16'd7) ? ST_WAIT : ST_CMD_LO;
        end
      end
      ST_WAIT: begin
        if (w_tick && r_idx == WAIT_LAST) w_next = ST_RD_LO;
      end
      ST_RD_LO: begin
        w_clk = 1'b0;
        if (w_tick) w_next = ST_RD_HI;
      end
      ST_RD_HI: begin
        if (w_tick) begin
          w_next = (r_idx == 16'd31) ? ST_STOP : ST_RD_LO;
        end
      end
      ST_STOP: begin
        w_stb = 1'b1;
        if (w_tick) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_raw   <= '0;
      r_keys  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_START: r_idx <= '0;
          ST_CMD_HI: begin
            r_idx <= (r_idx == 16'd7) ? '0 : r_idx + 16'd1;
          end
          ST_WAIT: begin
            r_idx <= (r_idx == WAIT_LAST) ? '0 : r_idx + 16'd1;
          end
          ST_RD_HI: begin
            r_shift[r_idx[4:0]] <= DIO_IN;
            r_idx <= (r_idx == 16'd31) ? '0 : r_idx + 16'd1;
          end
          ST_STOP: begin
            r_raw   <= r_shift;
            r_keys  <= decode_keys(r_shift);
            r_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign BUSY       = w_busy;
  assign KEYS       = r_keys;
  assign RAW        = r_raw;
  assign KEYS_VALID = r_valid;
  assign TM1638_STB = w_stb;
  assign TM1638_CLK = w_clk;
  assign DIO_OUT    = w_do;
  assign DIO_OE     = w_oe;

endmodule
